// File: rtl/line_buffer_win.sv
// Single-line pixel buffer: fills one line, then serves WIN-wide windows centred on a read pointer.
// Out-of-line taps are zero-padded or edge-replicated according to BORDER.
module line_buffer_win #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int WIN      = 3,
  parameter int BORDER   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_data_valid,
  input  logic                    i_rd_data_rdy,
  output logic [WIN*DATA_W-1:0]   o_data,
  output logic                    o_data_valid,
  output logic                    o_line_rdy,
  output logic                    o_wr_ovf,
  output logic                    o_rd_unf
);

  localparam int              PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int              HALF  = (WIN - 1) / 2;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]      mem [LINE_LEN];
  logic                   wr_acc, rd_acc;
  logic [WIN*DATA_W-1:0]  window;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:        if (wr_acc && wr_ptr == LAST) state_nxt = FULL;
      FULL, DRAIN: if (rd_acc) state_nxt = (rd_ptr == LAST) ? FILL : DRAIN;
      default:     state_nxt = FILL;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o_line_rdy = 1'b0;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    unique case (state)
      FILL: begin
        wr_acc = i_data_valid;
      end
      FULL, DRAIN: begin
        o_line_rdy = 1'b1;
        rd_acc     = i_rd_data_rdy;
      end
      default: ;
    endcase
  end

  // NOTE: the line store has no reset; a stale line is unreachable until a full new line is written.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_data;
  end

  // Tap 0 is the lowest address and lands in the MSBs; out-of-range taps never wrap.
  always_comb begin
    int                addr;
    logic [DATA_W-1:0] tap;
    window = '0;
    addr   = 0;
    tap    = '0;
    for (int k = 0; k < WIN; k++) begin
      addr = int'(rd_ptr) + k - HALF;
      if (addr < 0)
        tap = (BORDER != 0) ? mem[0] : '0;
      else if (addr > LINE_LEN - 1)
        tap = (BORDER != 0) ? mem[LAST] : '0;
      else
        tap = mem[addr[PTR_W-1:0]];
      window[(WIN-1-k)*DATA_W +: DATA_W] = tap;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_wr_ovf     <= 1'b0;
      o_rd_unf     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        o_data <= window;
      end
      o_data_valid <= rd_acc;
      o_wr_ovf     <= i_data_valid && o_line_rdy;
      o_rd_unf     <= i_rd_data_rdy && !o_line_rdy;
    end
  end

endmodule

// File: tb/tb_line_buffer_win.sv
// Bench for line_buffer_win: three configurations driven by directed and random steps,
// each compared every cycle against a per-line behavioural model.
module tb_line_buffer_win;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       i_rst;
  logic [7:0] a_d, c_d;
  logic       a_dv, a_rr, c_dv, c_rr;

  logic [23:0] d0_data, d1_data;
  logic [39:0] d2_data;
  logic v0, l0, o0, u0, v1, l1, o1, u1, v2, l2, o2, u2;

  int checks = 0;
  int errors = 0;

  line_buffer_win #(.DATA_W(8), .LINE_LEN(8), .WIN(3), .BORDER(0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(a_d), .i_data_valid(a_dv), .i_rd_data_rdy(a_rr),
    .o_data(d0_data), .o_data_valid(v0), .o_line_rdy(l0), .o_wr_ovf(o0), .o_rd_unf(u0));

  line_buffer_win #(.DATA_W(8), .LINE_LEN(8), .WIN(3), .BORDER(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(a_d), .i_data_valid(a_dv), .i_rd_data_rdy(a_rr),
    .o_data(d1_data), .o_data_valid(v1), .o_line_rdy(l1), .o_wr_ovf(o1), .o_rd_unf(u1));

  line_buffer_win #(.DATA_W(8), .LINE_LEN(5), .WIN(5), .BORDER(1)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(c_d), .i_data_valid(c_dv), .i_rd_data_rdy(c_rr),
    .o_data(d2_data), .o_data_valid(v2), .o_line_rdy(l2), .o_wr_ovf(o2), .o_rd_unf(u2));

  // Model: a stored line, a count of pixels written, a count of windows read, and whether the line is complete.
  typedef struct {
    logic [7:0]  px [8];
    int          wr;
    int          rd;
    bit          full;
    logic [39:0] data;
    bit          valid;
    bit          ovf;
    bit          unf;
  } model_t;

  model_t m0, m1, m2;

  function automatic model_t model_reset();
    model_t m;
    foreach (m.px[i]) m.px[i] = 8'h00;
    m.wr = 0; m.rd = 0; m.full = 0;
    m.data = '0; m.valid = 0; m.ovf = 0; m.unf = 0;
    return m;
  endfunction

  function automatic logic [39:0] model_window(model_t m, int len, int win, int border);
    logic [39:0] r = '0;
    int a, v;
    for (int k = 0; k < win; k++) begin
      a = m.rd + k - (win - 1) / 2;
      if (a < 0)             v = border ? m.px[0] : 0;
      else if (a > len - 1)  v = border ? m.px[len-1] : 0;
      else                   v = m.px[a];
      r = (r << 8) | 40'(v);
    end
    return r;
  endfunction

  function automatic model_t model_step(model_t m, bit dv, logic [7:0] d, bit rr,
                                        int len, int win, int border);
    model_t n = m;
    n.ovf   = dv && m.full;
    n.unf   = rr && !m.full;
    n.valid = rr && m.full;
    if (n.valid) n.data = model_window(m, len, win, border);
    if (!m.full && dv) begin
      n.px[m.wr] = d;
      n.wr = m.wr + 1;
      if (n.wr == len) begin n.wr = 0; n.full = 1; end
    end
    if (m.full && rr) begin
      n.rd = m.rd + 1;
      if (n.rd == len) begin n.rd = 0; n.full = 0; end
    end
    return n;
  endfunction

  task automatic check(string tag, logic [39:0] obs, logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string name, model_t m, logic [39:0] data,
                           logic v, logic rdy, logic ovf, logic unf);
    check({name, ".data"},     data,          m.data);
    check({name, ".valid"},    {39'b0, v},    {39'b0, m.valid});
    check({name, ".line_rdy"}, {39'b0, rdy},  {39'b0, m.full});
    check({name, ".wr_ovf"},   {39'b0, ovf},  {39'b0, m.ovf});
    check({name, ".rd_unf"},   {39'b0, unf},  {39'b0, m.unf});
  endtask

  task automatic check_all();
    check_dut("d0", m0, {16'b0, d0_data}, v0, l0, o0, u0);
    check_dut("d1", m1, {16'b0, d1_data}, v1, l1, o1, u1);
    check_dut("d2", m2, d2_data,          v2, l2, o2, u2);
  endtask

  task automatic idle();
    a_dv = 0; a_rr = 0; a_d = 8'h00;
    c_dv = 0; c_rr = 0; c_d = 8'h00;
  endtask

  // One clock: inputs are held across the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge i_clk);
    #1;
    m0 = model_step(m0, a_dv, a_d, a_rr, 8, 3, 0);
    m1 = model_step(m1, a_dv, a_d, a_rr, 8, 3, 1);
    m2 = model_step(m2, c_dv, c_d, c_rr, 5, 5, 1);
    check_all();
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    m0 = model_reset(); m1 = model_reset(); m2 = model_reset();
    #12;
    check_all();
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Read before any line exists
    a_rr = 1; c_rr = 1;
    cycle();
    idle();

    // Fill 10..17; the final write coincides with an ignored read
    for (int i = 0; i < 8; i++) begin
      a_dv = 1; a_d = 8'h10 + 8'(i); a_rr = (i == 7);
      cycle();
    end
    idle();
    a_dv = 1; a_d = 8'hEE;
    cycle();
    idle();

    // Drain the line; the final read coincides with a dropped write
    for (int i = 0; i < 8; i++) begin
      a_rr = 1; a_dv = (i == 7); a_d = 8'hAA;
      cycle();
      if (i == 0) begin
        check("d0.first_win", {16'b0, d0_data}, 40'h00_0010_11);
        check("d1.first_win", {16'b0, d1_data}, 40'h00_0010_1011 & 40'hFF_FFFF);
      end
      if (i == 7) begin
        check("d0.last_win", {16'b0, d0_data}, 40'h00_0016_1700);
        check("d1.last_win", {16'b0, d1_data}, 40'h00_0016_1717);
      end
    end
    idle();
    cycle();

    // Partial line then asynchronous reset between edges
    for (int i = 0; i < 4; i++) begin
      a_dv = 1; a_d = 8'h20 + 8'(i);
      cycle();
    end
    idle();
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    m0 = model_reset(); m1 = model_reset(); m2 = model_reset();
    check_all();
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      a_dv = 1; a_d = 8'h30 + 8'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      a_rr = 1;
      cycle();
      if (i == 0) check("d0.after_rst_win", {16'b0, d0_data}, 40'h00_0000_3031);
    end
    idle();

    // Five-tap window on a five-pixel line with edge replication
    for (int i = 0; i < 5; i++) begin
      c_dv = 1; c_d = 8'(i + 1);
      cycle();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      c_rr = 1;
      cycle();
      if (i == 0) check("d2.first_win", d2_data, 40'h01_0101_0203);
      if (i == 4) check("d2.last_win",  d2_data, 40'h03_0405_0505);
    end
    idle();
    cycle();

    // Random traffic on both input groups
    for (int n = 0; n < 400; n++) begin
      a_dv = 1'($urandom_range(0, 1));
      a_rr = 1'($urandom_range(0, 1));
      a_d  = 8'($urandom);
      c_dv = 1'($urandom_range(0, 1));
      c_rr = 1'($urandom_range(0, 1));
      c_d  = 8'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
